apb_sram_slave: RTL and testbench

APB_SRAM_SLAVE -- requirements
Module: apb_sram_slave

---
 rtl/apb_sram_slave.sv | 142 ++++++++++++++
 tb/tb_apb_sram_slave.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/apb_sram_slave.sv
// APB3 word-addressed SRAM slave with a fixed number of wait states per transfer.
// Address, direction and write data are latched in the setup phase and held for the whole access.
module apb_sram_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int                  IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [2:0]          WAIT_C  = 3'(WAIT_STATES);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                  state_r, state_nx_s;
  logic [2:0]              cnt_r, cnt_nx_s;
  logic [ADDR_WIDTH-1:0]   addr_r, addr_nx_s;
  logic                    write_r, write_nx_s;
  logic [DATA_WIDTH-1:0]   wdata_r, wdata_nx_s;
  logic                    setup_s, access_s;
  logic                    ready_nx_s, err_nx_s, mem_we_s;
  logic [DATA_WIDTH-1:0]   rdata_nx_s;
  logic                    ready_r, err_r;
  logic [DATA_WIDTH-1:0]   rdata_r;
  logic [DATA_WIDTH-1:0]   mem_r [0:MEM_DEPTH-1];

  function automatic logic addr_oob(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= DEPTH_C);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  assign setup_s  = PSEL && !PENABLE;
  assign access_s = PSEL && PENABLE;

  // State, wait counter and setup-phase capture registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r <= IDLE;
      cnt_r   <= 3'd0;
      addr_r  <= '0;
      write_r <= 1'b0;
      wdata_r <= '0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      addr_r  <= addr_nx_s;
      write_r <= write_nx_s;
      wdata_r <= wdata_nx_s;
    end
  end

  // Next-state: accept setup in IDLE, count down waits, then complete or abort.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    addr_nx_s  = addr_r;
    write_nx_s = write_r;
    wdata_nx_s = wdata_r;
    case (state_r)
      IDLE: begin
        if (setup_s) begin
          state_nx_s = ACCESS;
          cnt_nx_s   = WAIT_C;
          addr_nx_s  = PADDR;
          write_nx_s = PWRITE;
          wdata_nx_s = PWDATA;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ACCESS: begin
        if (!access_s) begin
          state_nx_s = IDLE;
          cnt_nx_s   = 3'd0;
        end else if (cnt_r != 3'd0) begin
          cnt_nx_s   = cnt_r - 3'd1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = 3'd0;
      end
    endcase
  end

  // Outputs are precomputed from the next state so PREADY/PSLVERR/PRDATA come straight from flops.
  always_comb begin
    ready_nx_s = (state_nx_s == ACCESS) && (cnt_nx_s == 3'd0);
    err_nx_s   = ready_nx_s && addr_oob(addr_nx_s);
    if (ready_nx_s && !write_nx_s && !err_nx_s) begin
      rdata_nx_s = mem_r[addr_idx(addr_nx_s)];
    end else begin
      rdata_nx_s = '0;
    end
    mem_we_s = ready_r && access_s && write_r && !err_r;
  end

  // Registered APB response.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= '0;
    end else begin
      ready_r <= ready_nx_s;
      err_r   <= err_nx_s;
      rdata_r <= rdata_nx_s;
    end
  end

  // Storage array; deliberately not reset so contents survive PRESETn.
  always_ff @(posedge PCLK) begin
    if (mem_we_s) begin
      mem_r[addr_idx(addr_r)] <= wdata_r;
    end
  end

  assign PREADY  = ready_r;
  assign PSLVERR = err_r;
  assign PRDATA  = rdata_r;

endmodule

// File: tb/tb_apb_sram_slave.sv
// Randomized plus directed bench for apb_sram_slave, checked against a per-instance word-array model.
// Three instances cover WAIT_STATES = 1, 0 and 3.
module tb_apb_sram_slave;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic        psel    [3];
  logic        penable [3];
  logic        pwrite  [3];
  logic [7:0]  paddr   [3];
  logic [31:0] pwdata  [3];
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];

  logic [31:0] model_mem [3][64];
  int          checks = 0;
  int          errors = 0;

  always #5 pclk = ~pclk;

  apb_sram_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_DEPTH(64), .WAIT_STATES(1)) u_dut_ws1 (
    .PCLK(pclk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_sram_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_DEPTH(64), .WAIT_STATES(0)) u_dut_ws0 (
    .PCLK(pclk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  apb_sram_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_DEPTH(64), .WAIT_STATES(3)) u_dut_ws3 (
    .PCLK(pclk), .PRESETn(rst_n), .PSEL(psel[2]), .PENABLE(penable[2]), .PWRITE(pwrite[2]),
    .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  function automatic int ws_of(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input int i, input string tag);
    check($sformatf("i%0d %s pready", i, tag), 32'(pready[i]), 32'd0);
    check($sformatf("i%0d %s pslverr", i, tag), 32'(pslverr[i]), 32'd0);
    check($sformatf("i%0d %s prdata", i, tag), prdata[i], 32'd0);
  endtask

  // Called just after a rising edge; returns just after a rising edge with the bus idle.
  // During ACCESS the address/data/direction are scrambled to prove the captured copies are used.
  task automatic xfer(input int i, input bit wr, input logic [7:0] a, input logic [31:0] d,
                      input logic [7:0] alt, input int abort_at);
    int          ws;
    bit          err;
    bit          rdy;
    bit          aborted;
    logic [31:0] exp_rd;
    string       tag;
    ws      = ws_of(i);
    err     = (a >= 8'd64);
    aborted = 1'b0;
    psel[i] = 1'b1; penable[i] = 1'b0; pwrite[i] = wr; paddr[i] = a; pwdata[i] = d;
    @(negedge pclk);
    check($sformatf("i%0d a=%0d setup pready", i, a), 32'(pready[i]), 32'd0);
    @(posedge pclk); #1;
    penable[i] = 1'b1; paddr[i] = alt; pwdata[i] = ~d; pwrite[i] = ~wr;
    for (int k = 0; k <= ws && !aborted; k++) begin
      @(negedge pclk);
      rdy    = (k == ws);
      exp_rd = (rdy && !wr && !err) ? model_mem[i][a[5:0]] : 32'd0;
      tag    = $sformatf("i%0d %s a=%0d k=%0d", i, wr ? "wr" : "rd", a, k);
      check({tag, " pready"}, 32'(pready[i]), 32'(rdy));
      check({tag, " pslverr"}, 32'(pslverr[i]), 32'(rdy && err));
      check({tag, " prdata"}, prdata[i], exp_rd);
      if (k == abort_at) begin
        psel[i] = 1'b0;
        aborted = 1'b1;
      end
    end
    @(posedge pclk); #1;
    psel[i] = 1'b0; penable[i] = 1'b0;
    if (aborted) begin
      @(negedge pclk);
      check_quiet(i, $sformatf("a=%0d after abort", a));
      @(posedge pclk); #1;
    end else if (wr && !err) begin
      model_mem[i][a[5:0]] = d;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          ri;
    bit          rwr;
    logic [7:0]  ra;
    int          rab;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0; paddr[i] = 8'd0; pwdata[i] = 32'd0;
    end
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    for (int i = 0; i < 3; i++) check_quiet(i, "reset");
    @(posedge pclk); #1;
    rst_n = 1'b1;

    // Give every word a known value (memory is unreset).
    for (int i = 0; i < 3; i++)
      for (int a = 0; a < 64; a++)
        xfer(i, 1'b1, 8'(a), $urandom, 8'($urandom), -1);

    // Single wait state write/read.
    xfer(0, 1'b1, 8'd5, 32'hDEADBEEF, 8'd6, -1);
    xfer(0, 1'b0, 8'd5, 32'd0, 8'd6, -1);
    // Zero wait states, back-to-back.
    xfer(1, 1'b1, 8'd3, 32'h12345678, 8'd4, -1);
    xfer(1, 1'b0, 8'd3, 32'd0, 8'd4, -1);
    // Out-of-range accesses.
    xfer(0, 1'b1, 8'd64, 32'hA5A5A5A5, 8'd0, -1);
    xfer(0, 1'b0, 8'd0, 32'd0, 8'd64, -1);
    xfer(0, 1'b0, 8'd64, 32'd0, 8'd0, -1);
    // Address changes 7->9 during waits.
    xfer(2, 1'b1, 8'd7, 32'h0BADF00D, 8'd9, -1);
    xfer(2, 1'b0, 8'd7, 32'd0, 8'd9, -1);
    xfer(2, 1'b0, 8'd9, 32'd0, 8'd7, -1);
    // PSEL dropped in the first wait cycle.
    xfer(2, 1'b1, 8'd2, 32'h55AA55AA, 8'd2, 0);
    xfer(2, 1'b0, 8'd2, 32'd0, 8'd2, -1);

    // Reset in the PREADY cycle of a write to addr 4.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'd4; pwdata[0] = 32'hCAFEF00D;
    @(posedge pclk); #1;
    penable[0] = 1'b1;
    @(posedge pclk); #1;
    check("i0 prereset pready", 32'(pready[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check_quiet(i, "async reset");
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    check_quiet(0, "held reset");
    @(posedge pclk); #1;
    rst_n = 1'b1;
    xfer(0, 1'b0, 8'd4, 32'd0, 8'd5, -1);
    xfer(0, 1'b0, 8'd5, 32'd0, 8'd4, -1);
    xfer(0, 1'b1, 8'd4, 32'h44443333, 8'd5, -1);
    xfer(0, 1'b0, 8'd4, 32'd0, 8'd5, -1);

    // Randomized traffic with occasional errors, aborts and idle gaps.
    for (int n = 0; n < 300; n++) begin
      ri  = $urandom_range(0, 2);
      rwr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) ra = 8'(64 + $urandom_range(0, 191));
      else                           ra = 8'($urandom_range(0, 63));
      rab = -1;
      if ($urandom_range(0, 7) == 0) rab = $urandom_range(0, ws_of(ri));
      xfer(ri, rwr, ra, $urandom, 8'($urandom), rab);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge pclk); #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
